// File: rtl/decoder_rr_arbiter_if.sv
// Bus between the requesters and the round-robin decoder arbiter.
// slave = arbiter side, master = requester/decoder side.
interface decoder_rr_arbiter_if;
  logic [15:0] req_i;
  logic        done_i;
  logic        dec_enable_o;
  logic [3:0]  dec_sel_o;
  logic        grant_valid_o;
  logic [3:0]  grant_id_o;
  logic        timeout_o;

  modport slave (
    input  req_i,
    input  done_i,
    output dec_enable_o,
    output dec_sel_o,
    output grant_valid_o,
    output grant_id_o,
    output timeout_o
  );

  modport master (
    output req_i,
    output done_i,
    input  dec_enable_o,
    input  dec_sel_o,
    input  grant_valid_o,
    input  grant_id_o,
    input  timeout_o
  );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter driving a shared 4-to-16 decoder (active-low enable), 16 requesters.
// Optional macro TIMEOUT_EN: forced release after MAX_HOLD busy cycles with a timeout pulse.
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 255,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  decoder_rr_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  if ((2 ** CNT_W) <= MAX_HOLD || MAX_HOLD < 1) begin : g_bad_params
    $error("decoder_rr_arbiter: need 2**CNT_W > MAX_HOLD >= 1");
  end

  state_e      state_q;
  logic        dec_enable_q;
  logic [3:0]  dec_sel_q;
  logic        grant_valid_q;
  logic [3:0]  grant_id_q;
  logic [3:0]  last_id_q;
  logic        win_vld_d;
  logic [3:0]  win_id_d;

  // Search starts just after the previous owner; the previous owner itself is checked last.
  function automatic logic [4:0] rr_pick(input logic [15:0] req, input logic [3:0] last);
    logic [4:0] res;
    logic [3:0] idx;
    res = 5'd0;
    for (int k = 1; k <= 16; k++) begin
      idx = last + k[3:0];
      if (!res[4] && req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Round-robin winner for the current request vector.
  always_comb begin
    {win_vld_d, win_id_d} = rr_pick(bus.req_i, last_id_q);
  end

`ifdef TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q;
  logic             timeout_q;

  // Arbitration FSM with hold-time watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      dec_enable_q  <= 1'b1;
      dec_sel_q     <= 4'd0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= 4'd0;
      last_id_q     <= 4'd15;
      hold_cnt_q    <= '0;
      timeout_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          timeout_q <= 1'b0;
          if (win_vld_d) begin
            state_q       <= ST_BUSY;
            dec_sel_q     <= win_id_d;
            grant_id_q    <= win_id_d;
            dec_enable_q  <= 1'b0;
            grant_valid_q <= 1'b1;
            hold_cnt_q    <= '0;
          end
        end
        ST_BUSY: begin
          if (bus.done_i || (hold_cnt_q == CNT_W'(MAX_HOLD - 1))) begin
            state_q       <= ST_IDLE;
            dec_enable_q  <= 1'b1;
            grant_valid_q <= 1'b0;
            last_id_q     <= grant_id_q;
            timeout_q     <= ~bus.done_i;
          end else begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          dec_enable_q  <= 1'b1;
          grant_valid_q <= 1'b0;
          timeout_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  // Arbitration FSM; a grant is held until its owner signals done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      dec_enable_q  <= 1'b1;
      dec_sel_q     <= 4'd0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= 4'd0;
      last_id_q     <= 4'd15;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld_d) begin
            state_q       <= ST_BUSY;
            dec_sel_q     <= win_id_d;
            grant_id_q    <= win_id_d;
            dec_enable_q  <= 1'b0;
            grant_valid_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (bus.done_i) begin
            state_q       <= ST_IDLE;
            dec_enable_q  <= 1'b1;
            grant_valid_q <= 1'b0;
            last_id_q     <= grant_id_q;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          dec_enable_q  <= 1'b1;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.timeout_o = 1'b0;
`endif

  assign bus.dec_enable_o  = dec_enable_q;
  assign bus.dec_sel_o     = dec_sel_q;
  assign bus.grant_valid_o = grant_valid_q;
  assign bus.grant_id_o    = grant_id_q;

endmodule
